// File: rtl/prbs_checker.sv
// PRBS checker: self-synchronising receiver for the XNOR-LFSR PRBS stream, with lock detection and BER counters.
// Latency: err_pulse, err_count and bit_count update one cycle after the sampled bit.
// Backpressure: none; the checker accepts a bit on every in_valid cycle and holds all state otherwise.

package lfsr_package;
  // Maximal-length XNOR tap sets (1-based tap positions), indexed by LFSR length.
  parameter int LFSR_TAPS [0:32][0:3] = '{
    '{0, 0, 0, 0},     '{0, 0, 0, 0},     '{2, 1, 0, 0},     '{3, 2, 0, 0},
    '{4, 3, 0, 0},     '{5, 3, 0, 0},     '{6, 5, 0, 0},     '{7, 6, 0, 0},
    '{8, 6, 5, 4},     '{9, 5, 0, 0},     '{10, 7, 0, 0},    '{11, 9, 0, 0},
    '{12, 6, 4, 1},    '{13, 4, 3, 1},    '{14, 5, 3, 1},    '{15, 14, 0, 0},
    '{16, 15, 13, 4},  '{17, 14, 0, 0},   '{18, 11, 0, 0},   '{19, 6, 2, 1},
    '{20, 17, 0, 0},   '{21, 19, 0, 0},   '{22, 21, 0, 0},   '{23, 18, 0, 0},
    '{24, 23, 22, 17}, '{25, 22, 0, 0},   '{26, 6, 2, 1},    '{27, 5, 2, 1},
    '{28, 25, 0, 0},   '{29, 27, 0, 0},   '{30, 6, 4, 1},    '{31, 28, 0, 0},
    '{32, 22, 2, 1}
  };
  // Number of taps per length; -1 marks an unsupported length.
  parameter int LFSR_N_TAPS [0:32] = '{
    -1, -1, 2, 2, 2, 2, 2, 2, 4, 2, 2, 2, 4, 4, 4, 2,
     4,  2, 2, 4, 2, 2, 2, 2, 4, 2, 4, 4, 2, 2, 4, 2,
     4
  };
endpackage

module prbs_checker
  import lfsr_package::*;
#(
  parameter int n           = 16,
  parameter int LOCK_CNT    = 32,
  parameter int WINDOW      = 256,
  parameter int UNLOCK_ERRS = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             rx_bit,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  // Lengths outside the table map to entry 0, which is flagged unsupported.
  localparam int NI     = (n >= 0 && n <= 32) ? n : 0;
  localparam int N_TAPS = LFSR_N_TAPS[NI];

  localparam int FILL_W  = $clog2(n + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WB_W    = $clog2(WINDOW + 1);
  localparam int WE_W    = $clog2(UNLOCK_ERRS + 1);

  localparam logic [0:0] S_SEARCH = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  if (N_TAPS < 1) begin : g_bad_n
    $error("prbs_checker: unsupported LFSR length n=%0d", n);
  end

  // Tap positions folded into a bit mask so the prediction is one reduction.
  function automatic logic [n-1:0] tap_mask();
    logic [n-1:0] m;
    int           idx;
    m = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < N_TAPS) begin
        idx = LFSR_TAPS[NI][k] - 1;
        if (idx >= 0 && idx < n) m[idx] = 1'b1;
      end
    end
    return m;
  endfunction

  localparam logic [n-1:0] TAP_MASK = tap_mask();

  logic [0:0]         state_q, state_d;
  logic [n-1:0]       sr_q, sr_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [WB_W-1:0]    win_bits_q, win_bits_d;
  logic [WE_W-1:0]    win_errs_q, win_errs_d;
  logic               err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;

  logic               pred;
  logic               bit_err;
  logic               sr_lockup;
  logic [WB_W-1:0]    wb_next;
  logic [WE_W-1:0]    we_next;

  assign pred      = ~(^(sr_q & TAP_MASK));
  assign bit_err   = rx_bit ^ pred;
  // All-ones is the XNOR lockup state; it must never count as a match.
  assign sr_lockup = &sr_q;
  assign wb_next   = win_bits_q + WB_W'(1);
  assign we_next   = win_errs_q + WE_W'(bit_err);

  // Next-state logic: self-sync search, flywheel tracking while locked, counters.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_bits_d  = win_bits_q;
    win_errs_d  = win_errs_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    bit_cnt_d   = bit_cnt_q;

    if (in_valid) begin
      if (state_q == S_SEARCH) begin
        // Load received bits directly so the local copy converges to the stream.
        sr_d = {sr_q[n-2:0], rx_bit};
        if (fill_q != FILL_W'(n)) begin
          fill_d = fill_q + FILL_W'(1);
        end else if (!bit_err && !sr_lockup) begin
          if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
            state_d    = S_LOCKED;
            match_d    = '0;
            win_bits_d = '0;
            win_errs_d = '0;
          end else begin
            match_d = match_q + MATCH_W'(1);
          end
        end else begin
          match_d = '0;
        end
      end else begin
        // Flywheel on the prediction so a line error costs exactly one count.
        sr_d        = {sr_q[n-2:0], pred};
        err_pulse_d = bit_err;
        if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_err && err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        if (we_next == WE_W'(UNLOCK_ERRS)) begin
          state_d    = S_SEARCH;
          fill_d     = '0;
          match_d    = '0;
          win_bits_d = '0;
          win_errs_d = '0;
        end else if (wb_next == WB_W'(WINDOW)) begin
          win_bits_d = '0;
          win_errs_d = '0;
        end else begin
          win_bits_d = wb_next;
          win_errs_d = we_next;
        end
      end
    end

    // Clear overrides any count made in the same cycle.
    if (clear) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end
  end

  // State registers; reset discards lock and every partial count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_SEARCH;
      sr_q        <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      win_bits_q  <= '0;
      win_errs_q  <= '0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_bits_q  <= win_bits_d;
      win_errs_q  <= win_errs_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  assign locked    = (state_q == S_LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_count = err_cnt_q;
  assign bit_count = bit_cnt_q;

endmodule
